// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory controller.
//   DEF_* : default geometry of the data memory (byte-address width,
//           log2 bytes per word, implemented word count).
//   dmem_word_t : one data word at the default geometry.
//   dbits_of()  : word width for a given log2(bytes per word).
package dmem_pkg;

  localparam int DEF_DMEMADDRBITS = 13;
  localparam int DEF_DMEMWORDBITS = 2;
  localparam int DEF_DMEMWORDS    = 2048;

  function automatic int dbits_of(input int wordbits);
    return 8 << wordbits;
  endfunction

  localparam int DEF_DBITS     = dbits_of(DEF_DMEMWORDBITS);
  localparam int DEF_WADDRBITS = DEF_DMEMADDRBITS - DEF_DMEMWORDBITS;

  typedef logic [DEF_DBITS-1:0] dmem_word_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: plain synchronous single-port RAM.
//   clk   : rising-edge clock
//   we    : write enable
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, write-first on a same-edge write
// There is no reset on the storage or the read register so the array maps
// directly onto a block RAM with its output register.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DEF_DMEMWORDS,
  parameter int IDXW   = 11,
  parameter int DATA_W = DEF_DBITS
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDXW-1:0]   idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
      rdata    <= wdata;
    end else begin
      rdata    <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_controller.sv
// dmem_controller: word-addressed data-memory controller.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   wrtEn : write enable, sampled on the rising edge
//   in    : write data (DBITS)
//   addr  : word index (DMEMADDRBITS-DMEMWORDBITS bits), not a byte address
//   out   : read data, one cycle latency, write-first
// Adds reset gating and an out-of-range guard around dmem_array. Storage is
// never cleared; only the visible read data is forced to zero.
// DMEMWORDS must not exceed 2**(DMEMADDRBITS-DMEMWORDBITS).
module dmem_controller
  import dmem_pkg::*;
#(
  parameter int DMEMADDRBITS = DEF_DMEMADDRBITS,
  parameter int DMEMWORDBITS = DEF_DMEMWORDBITS,
  parameter int DMEMWORDS    = DEF_DMEMWORDS,
  localparam int DBITS       = dbits_of(DMEMWORDBITS),
  localparam int AW          = DMEMADDRBITS - DMEMWORDBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrtEn,
  input  logic [DBITS-1:0] in,
  input  logic [AW-1:0]    addr,
  output logic [DBITS-1:0] out
);

  localparam int            IDXW    = (DMEMWORDS > 1) ? $clog2(DMEMWORDS) : 1;
  localparam logic [AW:0]   WORDS_L = (AW+1)'(DMEMWORDS);

  logic             in_range;
  logic             we;
  logic             rd_valid_q;
  logic [DBITS-1:0] rdata;

  assign in_range = ({1'b0, addr} < WORDS_L);

  // reset is used as data here so a write on an edge that sees reset low
  // is dropped, including the very edge on which reset is asserted.
  assign we = wrtEn & reset & in_range;

  dmem_array #(
    .DEPTH  (DMEMWORDS),
    .IDXW   (IDXW),
    .DATA_W (DBITS)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (addr[IDXW-1:0]),
    .wdata (in),
    .rdata (rdata)
  );

  // Remembers whether the last access produced real data. An out-of-range
  // access reads whatever the truncated index points at, so it is masked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= in_range;
    end
  end

  // Masking after the RAM register keeps the array reset-free while still
  // clearing out asynchronously the moment reset drops.
  assign out = (reset && rd_valid_q) ? rdata : '0;

endmodule

// File: tb/tb_dmem_controller.sv
module tb_dmem_controller;
  import dmem_pkg::*;

  logic        clk;
  logic        reset;
  logic        wrtEn;
  dmem_word_t  din;
  logic [10:0] addr;
  dmem_word_t  out_a;
  dmem_word_t  out_b;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  typedef struct {
    dmem_word_t exp;
    bit         chk;
    string      tag;
  } sb_t;

  sb_t        qa[$];
  sb_t        qb[$];
  dmem_word_t ma [int];
  dmem_word_t mb [int];

  dmem_controller u_a (
    .clk   (clk),
    .reset (reset),
    .wrtEn (wrtEn),
    .in    (din),
    .addr  (addr),
    .out   (out_a)
  );

  dmem_controller #(.DMEMWORDS(1024)) u_b (
    .clk   (clk),
    .reset (reset),
    .wrtEn (wrtEn),
    .in    (din),
    .addr  (addr),
    .out   (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input dmem_word_t obs, input dmem_word_t exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access per call: drive on the falling edge, predict both instances,
  // then compare just after the rising edge.
  task automatic step(input logic rst, input logic we, input dmem_word_t d,
                      input logic [10:0] a, input string tag);
    sb_t ea;
    sb_t eb;
    int  k;
    @(negedge clk);
    reset = rst;
    wrtEn = we;
    din   = d;
    addr  = a;
    k     = int'(a);

    ea.exp = '0; ea.chk = 1'b1; ea.tag = {tag, "/2048"};
    if (rst && k < 2048) begin
      if (we) begin
        ma[k] = d;
        ea.exp = d;
      end else if (ma.exists(k)) begin
        ea.exp = ma[k];
      end else begin
        ea.chk = 1'b0;
      end
    end

    eb.exp = '0; eb.chk = 1'b1; eb.tag = {tag, "/1024"};
    if (rst && k < 1024) begin
      if (we) begin
        mb[k] = d;
        eb.exp = d;
      end else if (mb.exists(k)) begin
        eb.exp = mb[k];
      end else begin
        eb.chk = 1'b0;
      end
    end

    qa.push_back(ea);
    qb.push_back(eb);

    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    if (ea.chk) check(ea.tag, out_a, ea.exp);
    if (eb.chk) check(eb.tag, out_b, eb.exp);
  endtask

  initial begin
    logic [10:0] pick [8];
    pick = '{11'd0, 11'd3, 11'd5, 11'd476, 11'd1023, 11'd1024, 11'd1500, 11'd2047};

    reset = 1'b0;
    wrtEn = 1'b0;
    din   = '0;
    addr  = '0;
    #1;
    check("reset_state_a", out_a, '0);
    check("reset_state_b", out_b, '0);

    step(1'b0, 1'b1, 32'hF, 11'd0, "rst_hold0");
    step(1'b0, 1'b1, 32'hF, 11'd0, "rst_hold1");
    step(1'b1, 1'b0, 32'h0, 11'd0, "rst_release");

    step(1'b1, 1'b1, 32'hF, 11'd0, "wr0");
    step(1'b1, 1'b0, 32'h0, 11'd0, "rd0_a");
    step(1'b1, 1'b0, 32'h0, 11'd0, "rd0_b");
    step(1'b1, 1'b0, 32'h0, 11'd0, "rd0_c");

    step(1'b1, 1'b1, 32'hDEADBEEF, 11'd5, "wfirst5");
    step(1'b1, 1'b0, 32'h0, 11'd5, "rd5");

    step(1'b1, 1'b1, 32'h1, 11'd0, "wr_lo");
    step(1'b1, 1'b1, 32'h2, 11'd2047, "wr_top");
    step(1'b1, 1'b0, 32'h0, 11'd0, "rd_lo");
    step(1'b1, 1'b0, 32'h0, 11'd2047, "rd_top");

    step(1'b1, 1'b1, 32'hA5A5A5A5, 11'd3, "wr3");
    #2;
    reset = 1'b0;
    #1;
    check("async_clr_a", out_a, '0);
    check("async_clr_b", out_b, '0);
    step(1'b1, 1'b0, 32'h0, 11'd3, "rd3_after_pulse");
    step(1'b0, 1'b1, 32'h12345678, 11'd3, "wr_in_reset");
    step(1'b1, 1'b0, 32'h0, 11'd3, "rd3_retained");

    step(1'b1, 1'b1, 32'h55, 11'd476, "wr476");
    step(1'b1, 1'b1, 32'h77, 11'd1500, "wr1500");
    step(1'b1, 1'b0, 32'h0, 11'd1500, "rd1500");
    step(1'b1, 1'b0, 32'h0, 11'd476, "rd476_nowrap");
    step(1'b1, 1'b1, 32'h99, 11'd1023, "wr1023");
    step(1'b1, 1'b1, 32'h88, 11'd1024, "wr1024");
    step(1'b1, 1'b0, 32'h0, 11'd1023, "rd1023");
    step(1'b1, 1'b0, 32'h0, 11'd0, "rd0_nowrap");

    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), $urandom,
           pick[$urandom_range(0, 7)], $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
